// File: rtl/proc_core_pkg.sv
// proc_core_pkg
// Shared definitions for the proc_core processor slice: opcode encodings,
// instruction field bit positions and the sequencer state type.
// Optional feature macro used by the slice: PROC_CORE_CALL_EN (CALL/RET opcodes).
// Ports: none (package only).

package proc_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BNZ  = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 9;
  localparam int RB_MSB  = 8;
  localparam int RB_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    WAIT
  } state_t;

endpackage

// File: rtl/proc_core_alu.sv
// proc_core_alu
// Combinational ALU for proc_core. ADD/ADDI share one adder; SUB reports the
// unsigned borrow as carry; logic ops clear carry.
// Ports:
//   a, b  in  DATA_W  operands (b is already the zero-extended immediate for ADDI)
//   op    in  4       instruction opcode
//   y     out DATA_W  result, modulo 2^DATA_W
//   z     out 1       y == 0
//   c     out 1       carry-out (ADD/ADDI) or borrow (SUB), else 0

module proc_core_alu
  import proc_core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] w_wide;

  // One extra bit on the adder captures the carry out of the top data bit.
  always_comb begin
    w_wide = '0;
    y      = '0;
    c      = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        w_wide = {1'b0, a} + {1'b0, b};
        y      = w_wide[DATA_W-1:0];
        c      = w_wide[DATA_W];
      end
      OP_SUB: begin
        y = a - b;
        c = (a < b);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: ;
    endcase
    z = (y == '0);
  end

endmodule

// File: rtl/proc_core.sv
// proc_core
// Multi-cycle 16-bit-instruction processor core. Fetches from an external
// synchronous ROM, executes one instruction every STEP_DIV cycles through a
// FETCH -> EXEC -> WAIT sequence, and presents OUT results with a pulse.
// Optional feature: define PROC_CORE_CALL_EN to build a STACK_DEPTH-entry
// return stack and enable CALL (0x9) / RET (0xA); otherwise both are NOPs.
// Ports:
//   clk           in  1       rising-edge clock
//   rst           in  1       synchronous active-high reset
//   instruction   in  16      ROM data, valid one cycle after address changes
//   address       out ADDR_W  program counter to the ROM
//   result        out DATA_W  last OUT value
//   result_pc     out ADDR_W  PC of the OUT that produced result
//   result_valid  out 1       one-cycle pulse when result updates
//   flags         out 2       {carry, zero}

module proc_core
  import proc_core_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int STEP_DIV    = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instruction,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] result_pc,
  output logic              result_valid,
  output logic [1:0]        flags
);

  if (DATA_W < 8) begin : g_bad_data_w
    $error("proc_core: DATA_W must be 8 or more");
  end
  if (ADDR_W < 1 || ADDR_W > 8) begin : g_bad_addr_w
    $error("proc_core: ADDR_W must be 1 to 8");
  end
  if (STEP_DIV < 2) begin : g_bad_step_div
    $error("proc_core: STEP_DIV must be 2 or more");
  end
  if (STACK_DEPTH < 1) begin : g_bad_stack_depth
    $error("proc_core: STACK_DEPTH must be 1 or more");
  end

  localparam int STEP_W = $clog2(STEP_DIV);
  // Last WAIT count value; unused when STEP_DIV == 2 since WAIT is skipped.
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'((STEP_DIV > 2) ? (STEP_DIV - 3) : 0);

  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_regs [8];
  logic                r_zero;
  logic                r_carry;
  logic [DATA_W-1:0]   r_result;
  logic [ADDR_W-1:0]   r_result_pc;
  logic                r_result_valid;

  logic [3:0]          w_opcode;
  logic [2:0]          w_ra;
  logic [2:0]          w_rb;
  logic [DATA_W-1:0]   w_imm;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_alu_y;
  logic                w_alu_z;
  logic                w_alu_c;

  assign w_opcode = instruction[OPC_MSB:OPC_LSB];
  assign w_ra     = instruction[RA_MSB:RA_LSB];
  assign w_rb     = instruction[RB_MSB:RB_LSB];
  assign w_imm    = DATA_W'(instruction[IMM_MSB:IMM_LSB]);
  assign w_target = instruction[ADDR_W-1:0];
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_a      = r_regs[w_ra];
  assign w_b      = (w_opcode == OP_ADDI) ? w_imm : r_regs[w_rb];

  proc_core_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (w_a),
    .b  (w_b),
    .op (w_opcode),
    .y  (w_alu_y),
    .z  (w_alu_z),
    .c  (w_alu_c)
  );

`ifdef PROC_CORE_CALL_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_pop_idx;

  // r_sp counts occupied entries, so the push slot is r_sp and the top is r_sp-1.
  assign w_push_idx = IDX_W'(r_sp);
  assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
`endif

  // The ROM output is consumed directly during EXEC: it was registered by the
  // ROM on the FETCH edge from a PC that has been stable since the last EXEC.
  // Everything architectural commits on the single EXEC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FETCH;
      r_step         <= '0;
      r_pc           <= '0;
      r_zero         <= 1'b0;
      r_carry        <= 1'b0;
      r_result       <= '0;
      r_result_pc    <= '0;
      r_result_valid <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
`ifdef PROC_CORE_CALL_EN
      r_sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
`endif
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        FETCH: r_state <= EXEC;
        EXEC: begin
          r_pc <= w_pc_inc;
          case (w_opcode)
            OP_NOP: ;
            OP_LDI: r_regs[w_ra] <= w_imm;
            OP_ADD, OP_SUB, OP_ADDI, OP_AND, OP_OR, OP_XOR: begin
              r_regs[w_ra] <= w_alu_y;
              r_zero       <= w_alu_z;
              r_carry      <= w_alu_c;
            end
            OP_JMP: r_pc <= w_target;
            OP_BZ:  if (r_zero)  r_pc <= w_target;
            OP_BNZ: if (!r_zero) r_pc <= w_target;
            OP_OUT: begin
              r_result       <= w_a;
              r_result_pc    <= r_pc;
              r_result_valid <= 1'b1;
            end
`ifdef PROC_CORE_CALL_EN
            // A full stack still takes the jump; the return address is lost.
            OP_CALL: begin
              r_pc <= w_target;
              if (r_sp != SP_FULL) begin
                r_stack[w_push_idx] <= w_pc_inc;
                r_sp                <= r_sp + SP_W'(1);
              end
            end
            OP_RET: begin
              if (r_sp != '0) begin
                r_pc <= r_stack[w_pop_idx];
                r_sp <= r_sp - SP_W'(1);
              end
            end
`else
            OP_CALL, OP_RET: ;
`endif
            default: ;
          endcase
          if (STEP_DIV == 2) begin
            r_state <= FETCH;
          end else begin
            r_state <= WAIT;
            r_step  <= '0;
          end
        end
        WAIT: begin
          if (r_step == STEP_LAST) begin
            r_state <= FETCH;
            r_step  <= '0;
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign address      = r_pc;
  assign result       = r_result;
  assign result_pc    = r_result_pc;
  assign result_valid = r_result_valid;
  assign flags        = {r_carry, r_zero};

endmodule

// File: tb/tb_proc_core.sv
// tb_proc_core
// Directed bench for proc_core: one core at STEP_DIV=2 (STACK_DEPTH=2) and one
// at STEP_DIV=5, each fed by its own synchronous ROM model. Programs are
// hand-encoded and expected values hand-computed. With PROC_CORE_CALL_EN
// defined, the nested CALL/RET program is also exercised.

module tb_proc_core;

  logic        clk = 1'b0;
  logic        rst2 = 1'b1;
  logic        rst5 = 1'b1;
  logic [15:0] instr2 = '0;
  logic [15:0] instr5 = '0;
  logic [3:0]  addr2, addr5;
  logic [15:0] res2, res5;
  logic [3:0]  resPc2, resPc5;
  logic        valid2, valid5;
  logic [1:0]  flags2, flags5;

  logic [15:0] rom2 [16];
  logic [15:0] rom5 [16];

  int checks = 0;
  int failures = 0;
  int curEdge = 0;

  always #5 clk = ~clk;

  // Synchronous ROMs: data appears one edge after the address is sampled.
  always @(posedge clk) begin
    instr2 <= rom2[addr2];
    instr5 <= rom5[addr5];
  end

  proc_core #(.DATA_W(16), .ADDR_W(4), .STEP_DIV(2), .STACK_DEPTH(2)) dut2 (
    .clk          (clk),
    .rst          (rst2),
    .instruction  (instr2),
    .address      (addr2),
    .result       (res2),
    .result_pc    (resPc2),
    .result_valid (valid2),
    .flags        (flags2)
  );

  proc_core #(.DATA_W(16), .ADDR_W(4), .STEP_DIV(5), .STACK_DEPTH(4)) dut5 (
    .clk          (clk),
    .rst          (rst5),
    .instruction  (instr5),
    .address      (addr5),
    .result       (res5),
    .result_pc    (resPc5),
    .result_valid (valid5),
    .flags        (flags5)
  );

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse reset on the selected core for two edges, release it on a falling
  // edge and restart the edge count so edge 1 is the first FETCH edge.
  task automatic applyStimulus(input int dutSel);
    @(negedge clk);
    if (dutSel == 2) rst2 = 1'b1; else rst5 = 1'b1;
    repeat (2) @(negedge clk);
    if (dutSel == 2) rst2 = 1'b0; else rst5 = 1'b0;
    curEdge = 0;
  endtask

  // Advance to the falling edge that follows rising edge e after release.
  task automatic runTo(input int e);
    while (curEdge < e) begin
      @(negedge clk);
      curEdge++;
    end
  endtask

  task automatic clearRoms();
    for (int i = 0; i < 16; i++) begin
      rom2[i] = 16'h0000;
      rom5[i] = 16'h0000;
    end
  endtask

  initial begin
    int pulses;
    int pulseEdge;

    clearRoms();
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst address", 32'(addr2), 32'h0);
    checkOutput("rst result", 32'(res2), 32'h0);
    checkOutput("rst result_pc", 32'(resPc2), 32'h0);
    checkOutput("rst result_valid", 32'(valid2), 32'h0);
    checkOutput("rst flags", 32'(flags2), 32'h0);

    // LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1
    $display("[TB] basic program");
    clearRoms();
    rom2[0] = 16'h1205;
    rom2[1] = 16'h1403;
    rom2[2] = 16'h2280;
    rom2[3] = 16'hF200;
    applyStimulus(2);
    pulses = 0;
    pulseEdge = 0;
    for (int k = 1; k <= 12; k++) begin
      runTo(k);
      if (valid2) begin
        pulses++;
        pulseEdge = k;
      end
      if (k == 2) checkOutput("t1 address after exec", 32'(addr2), 32'h1);
      if (k == 3) checkOutput("t1 address held", 32'(addr2), 32'h1);
    end
    checkOutput("t1 pulse count", 32'(pulses), 32'd1);
    checkOutput("t1 pulse edge", 32'(pulseEdge), 32'd8);
    checkOutput("t1 result", 32'(res2), 32'h8);
    checkOutput("t1 result_pc", 32'(resPc2), 32'h3);
    checkOutput("t1 flags", 32'(flags2), 32'h0);

    // LDI r1,3; LDI r2,3; SUB r1,r2; BZ 7; OUT r1 at 4 and 7
    $display("[TB] branch taken");
    clearRoms();
    rom2[0] = 16'h1203;
    rom2[1] = 16'h1403;
    rom2[2] = 16'h3280;
    rom2[3] = 16'hC007;
    rom2[4] = 16'hF200;
    rom2[7] = 16'hF200;
    applyStimulus(2);
    runTo(8);
    checkOutput("t2a address", 32'(addr2), 32'h7);
    checkOutput("t2a flags", 32'(flags2), 32'h1);
    runTo(10);
    checkOutput("t2a result", 32'(res2), 32'h0);
    checkOutput("t2a result_pc", 32'(resPc2), 32'h7);
    checkOutput("t2a result_valid", 32'(valid2), 32'h1);

    $display("[TB] branch not taken");
    rom2[1] = 16'h1404;
    applyStimulus(2);
    runTo(8);
    checkOutput("t2b address", 32'(addr2), 32'h4);
    checkOutput("t2b flags", 32'(flags2), 32'h2);
    runTo(10);
    checkOutput("t2b result", 32'(res2), 32'hFFFF);
    checkOutput("t2b result_pc", 32'(resPc2), 32'h4);

    // LDI r1,0xFF; ADD r1,r1 x8 -> 0xFF00; ADDI 0xFF; ADDI 1 wraps; OUT;
    // ADDI 0xFF; OUT; NOP; NOP; PC wraps 15 -> 0
    $display("[TB] carry wrap and pc wrap");
    clearRoms();
    rom2[0] = 16'h12FF;
    for (int i = 1; i <= 8; i++) rom2[i] = 16'h2240;
    rom2[9]  = 16'h42FF;
    rom2[10] = 16'h4201;
    rom2[11] = 16'hF200;
    rom2[12] = 16'h42FF;
    rom2[13] = 16'hF200;
    applyStimulus(2);
    runTo(20);
    checkOutput("t3 flags 0xFFFF", 32'(flags2), 32'h0);
    runTo(22);
    checkOutput("t3 flags wrap", 32'(flags2), 32'h3);
    runTo(24);
    checkOutput("t3 result wrap", 32'(res2), 32'h0);
    checkOutput("t3 result_pc", 32'(resPc2), 32'hB);
    checkOutput("t3 flags kept by OUT", 32'(flags2), 32'h3);
    runTo(26);
    checkOutput("t3 flags after addi", 32'(flags2), 32'h0);
    runTo(28);
    checkOutput("t3 result 0xFF", 32'(res2), 32'h00FF);
    runTo(32);
    checkOutput("t3 pc wrap", 32'(addr2), 32'h0);

    // LDI r1,5; SUB r3,r1; op 0xB; op 0x9 (NOP without the call feature);
    // OUT r1; OUT r3
    $display("[TB] undefined opcodes");
    clearRoms();
    rom2[0] = 16'h1205;
    rom2[1] = 16'h3640;
    rom2[2] = 16'hB240;
`ifdef PROC_CORE_CALL_EN
    rom2[3] = 16'h0000;
`else
    rom2[3] = 16'h9007;
`endif
    rom2[4] = 16'hF200;
    rom2[5] = 16'hF600;
    applyStimulus(2);
    runTo(10);
    checkOutput("t4 r1 unchanged", 32'(res2), 32'h5);
    checkOutput("t4 result_pc", 32'(resPc2), 32'h4);
    runTo(12);
    checkOutput("t4 r3", 32'(res2), 32'hFFFB);
    checkOutput("t4 flags unchanged", 32'(flags2), 32'h2);
    checkOutput("t4 address", 32'(addr2), 32'h6);

`ifdef PROC_CORE_CALL_EN
    // CALL 4; CALL 8; CALL 12 (stack full); RET; RET; RET (empty); OUT r0 at 2
    $display("[TB] call and return");
    clearRoms();
    rom2[0]  = 16'h9004;
    rom2[4]  = 16'h9008;
    rom2[8]  = 16'h900C;
    rom2[12] = 16'hA000;
    rom2[5]  = 16'hA000;
    rom2[1]  = 16'hA000;
    rom2[2]  = 16'hF000;
    applyStimulus(2);
    runTo(6);
    checkOutput("t6 call full jumps", 32'(addr2), 32'hC);
    runTo(8);
    checkOutput("t6 ret to 2nd site", 32'(addr2), 32'h5);
    runTo(10);
    checkOutput("t6 ret to 1st site", 32'(addr2), 32'h1);
    runTo(12);
    checkOutput("t6 ret empty", 32'(addr2), 32'h2);
    runTo(14);
    checkOutput("t6 out pc", 32'(resPc2), 32'h2);
    checkOutput("t6 out valid", 32'(valid2), 32'h1);
`endif

    // STEP_DIV=5: LDI r1,9; OUT r1; SUB r2,r1; reset mid-WAIT
    $display("[TB] step divider and reset in wait");
    rst2 = 1'b1;
    clearRoms();
    rom5[0] = 16'h1209;
    rom5[1] = 16'hF200;
    rom5[2] = 16'h3440;
    applyStimulus(5);
    runTo(3);
    checkOutput("t5 address held 3", 32'(addr5), 32'h1);
    runTo(6);
    checkOutput("t5 address held 6", 32'(addr5), 32'h1);
    runTo(7);
    checkOutput("t5 address next", 32'(addr5), 32'h2);
    checkOutput("t5 valid pulse", 32'(valid5), 32'h1);
    checkOutput("t5 result", 32'(res5), 32'h9);
    runTo(8);
    checkOutput("t5 valid drop", 32'(valid5), 32'h0);
    runTo(13);
    checkOutput("t5 flags pre-reset", 32'(flags5), 32'h2);
    checkOutput("t5 address pre-reset", 32'(addr5), 32'h3);
    rst5 = 1'b1;
    @(negedge clk);
    checkOutput("t5 rst address", 32'(addr5), 32'h0);
    checkOutput("t5 rst result", 32'(res5), 32'h0);
    checkOutput("t5 rst result_pc", 32'(resPc5), 32'h0);
    checkOutput("t5 rst valid", 32'(valid5), 32'h0);
    checkOutput("t5 rst flags", 32'(flags5), 32'h0);
    rst5 = 1'b0;
    curEdge = 0;
    runTo(1);
    checkOutput("t5 restart fetch addr", 32'(addr5), 32'h0);
    runTo(2);
    checkOutput("t5 restart exec addr", 32'(addr5), 32'h1);
    runTo(7);
    checkOutput("t5 restart result", 32'(res5), 32'h9);
    checkOutput("t5 restart result_pc", 32'(resPc5), 32'h1);
    checkOutput("t5 restart valid", 32'(valid5), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
